// File: rtl/global_buffer_pkg.sv
// Shared global-buffer types: bank geometry, bank request/response packets
// and the read-streamer FSM state encoding.
package global_buffer_pkg;

  localparam int BANK_ADDR_WIDTH = 17;
  localparam int BANK_DATA_WIDTH = 64;

  typedef struct packed {
    logic                       rd_en;
    logic [BANK_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic [BANK_DATA_WIDTH-1:0] rd_data;
    logic                       rd_data_valid;
  } rdrs_packet_t;

  typedef enum logic [1:0] {
    STRM_IDLE  = 2'd0,
    STRM_RUN   = 2'd1,
    STRM_DRAIN = 2'd2,
    STRM_DONE  = 2'd3
  } strm_state_e;

endpackage

// File: rtl/glb_fifo.sv
// First-word-fall-through FIFO used as the streamer response buffer.
// rdata reads as zero whenever the FIFO is empty.
module glb_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is honoured only if a pop frees a slot this edge.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
  end

  // Storage array; stale slots are never visible because rdata is gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy, cleared by reset (DEPTH is a power of two, so pointers wrap naturally).
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/glb_bank_rd_streamer.sv
// Global-buffer bank read streamer: issues strided bank reads under a credit
// scheme sized to the response buffer, and streams the returned words out in
// request order through a FWFT buffer.
module glb_bank_rd_streamer
  import global_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic [BANK_ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [BANK_ADDR_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]       cfg_num_words,
  output rdrq_packet_t               rdrq_packet,
  input  rdrs_packet_t               rdrs_packet,
  output logic [BANK_DATA_WIDTH-1:0] strm_data,
  output logic                       strm_valid,
  input  logic                       strm_ready,
  output logic                       busy,
  output logic                       done
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH+1)'(FIFO_DEPTH);

  strm_state_e                state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [BANK_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                       rd_en_q, rd_en_d;
  logic [CNT_WIDTH-1:0]       num_q, num_d, req_cnt_q, req_cnt_d;
  logic [CNT_WIDTH-1:0]       rsp_cnt_q, rsp_cnt_d, outst_q, outst_d;

  logic [FCW-1:0]   fifo_count;
  logic             fifo_full, fifo_empty;
  logic             active, rsp_acc, credit, issue;
  logic [CNT_WIDTH:0] in_use;

  assign active  = (state_q == STRM_RUN) || (state_q == STRM_DRAIN);
  // Responses only count while a stream is live and something is in flight.
  assign rsp_acc = rdrs_packet.rd_data_valid && active && (outst_q != '0);
  // Every in-flight request owns a buffer slot, so the buffer can never overflow.
  assign in_use  = {1'b0, outst_q} + (CNT_WIDTH+1)'(fifo_count);
  assign credit  = !fifo_full && (in_use < DEPTH_C);
  assign issue   = (state_q == STRM_RUN) && credit;

  assign rdrq_packet.rd_en   = rd_en_q;
  assign rdrq_packet.rd_addr = rd_addr_q;
  assign busy                = active;
  assign done                = (state_q == STRM_DONE);

  glb_fifo #(
    .DATA_WIDTH (BANK_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_acc),
    .wdata (rdrs_packet.rd_data),
    .pop   (strm_ready),
    .rdata (strm_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign strm_valid = !fifo_empty;

  // Next-state, request generation and counter updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    num_d     = num_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q + CNT_WIDTH'(rsp_acc);
    outst_d   = outst_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;

    case ({issue, rsp_acc})
      2'b10:   outst_d = outst_q + CNT_WIDTH'(1);
      2'b01:   outst_d = outst_q - CNT_WIDTH'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      STRM_IDLE, STRM_DONE: begin
        state_d = STRM_IDLE;
        if (cfg_start) begin
          addr_d    = cfg_start_addr;
          stride_d  = cfg_stride;
          num_d     = cfg_num_words;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          outst_d   = '0;
          state_d   = (cfg_num_words == '0) ? STRM_DONE : STRM_RUN;
        end
      end
      STRM_RUN: begin
        if (issue) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
          addr_d    = addr_q + stride_q;
          req_cnt_d = req_cnt_q + CNT_WIDTH'(1);
          if (req_cnt_q + CNT_WIDTH'(1) == num_q) state_d = STRM_DRAIN;
        end
      end
      STRM_DRAIN: begin
        if ((outst_q == '0) && fifo_empty && (rsp_cnt_q == num_q)) state_d = STRM_DONE;
      end
      default: state_d = STRM_IDLE;
    endcase
  end

  // State, latched configuration, counters and the registered bank request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= STRM_IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      num_q     <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      outst_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      num_q     <= num_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      outst_q   <= outst_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: doc/glb_bank_rd_streamer.md
GLB_BANK_RD_STREAMER -- requirements
Module: glb_bank_rd_streamer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, response buffer depth in words (power of two, >=2).
REQ-002 Parameter CNT_WIDTH, default 16, width of word counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 cfg_start  input  1  one-cycle pulse launching a stream; ignored unless state is IDLE or DONE.
REQ-006 cfg_start_addr  input  BANK_ADDR_WIDTH  first bank byte address.
REQ-007 cfg_stride  input  BANK_ADDR_WIDTH  byte increment between consecutive requests.
REQ-008 cfg_num_words  input  CNT_WIDTH  words to read; 0 means no requests.
REQ-009 rdrq_packet  output  rdrq_packet_t  read request to bank (rd_en, rd_addr).
REQ-010 rdrs_packet  input  rdrs_packet_t  read response from bank (rd_data, rd_data_valid).
REQ-011 strm_data  output  BANK_DATA_WIDTH  stream data, head of buffer.
REQ-012 strm_valid  output  1  strm_data valid.
REQ-013 strm_ready  input  1  consumer accepts word when strm_valid and strm_ready both 1.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 done  output  1  one-cycle pulse on entering DONE.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE/DONE + cfg_start: latch config, clear counters, go RUN; cfg_num_words=0 goes directly to DONE (done pulse next cycle, no requests).
REQ-018 RUN: rd_en=1 when credit available; rd_addr = start_addr + k*stride, k = request index, modulo 2^BANK_ADDR_WIDTH, zero-extended into rd_addr field.
REQ-019 Credit: request issued only if outstanding requests + buffer occupancy < FIFO_DEPTH; never overflow buffer regardless of bank latency.
REQ-020 Outstanding counter: +1 per issued request, -1 per rd_data_valid; simultaneous both: unchanged.
REQ-021 rd_data_valid writes rd_data into buffer same edge; rd_data_valid in IDLE/DONE or with zero outstanding is discarded and ignored.
REQ-022 After the cfg_num_words-th request issues: RUN -> DRAIN.
REQ-023 DRAIN -> DONE when outstanding=0, buffer empty, and responses received = cfg_num_words.
REQ-024 DONE -> IDLE next cycle unless cfg_start present (then RUN as REQ-017).
REQ-025 Buffer: FIFO, first-word-fall-through; strm_valid = not empty; strm_data stable while strm_valid & !strm_ready.
REQ-026 Buffer simultaneous push and pop when full or empty: both honoured, occupancy unchanged; pop when empty impossible (strm_valid=0).
REQ-027 Response order equals request order; streamer tags nothing.
REQ-028 cfg_start during RUN/DRAIN ignored; config changes after latch have no effect.
REQ-029 Peak throughput one word/cycle with strm_ready held 1 and bank latency < FIFO_DEPTH.

Reset
REQ-030 On reset=0: state IDLE, rd_en=0, rd_addr=0, strm_valid=0, strm_data=0, busy=0, done=0, all counters and buffer pointers 0.
REQ-031 Reset mid-stream aborts immediately; buffered and in-flight data discarded; responses arriving after release ignored per REQ-021.

Structure
REQ-032 rdrq_packet_t, rdrs_packet_t, BANK_ADDR_WIDTH, BANK_DATA_WIDTH from global_buffer_pkg/global_buffer_param; FSM state enum defined in global_buffer_pkg.
REQ-033 Response buffer is sub-module glb_fifo (parameters DATA_WIDTH, DEPTH; push, pop, full, empty, count).
REQ-034 rdrq_packet driven from registers; no combinational path from rdrs_packet or strm_ready to rdrq_packet.

Verification
REQ-035 start_addr=0x100, stride=8, num_words=4, bank latency 2, ready=1 -> rd_addr 0x100,0x108,0x110,0x118 on consecutive cycles; 4 words out in order; one done pulse.
REQ-036 num_words=10, ready=0 -> exactly 4 requests issued, then rd_en=0; ready=1 -> remaining 6 issue, all 10 words delivered, none lost.
REQ-037 start_addr=2^BANK_ADDR_WIDTH-8, stride=8, num_words=3 -> addresses wrap: max-8, 0x0, 0x8.
REQ-038 num_words=0 -> no rd_en, done pulse one cycle after start, busy stays 0.
REQ-039 reset=0 asserted with 2 requests outstanding -> all outputs zero next cycle; late rd_data_valid produces no strm_valid.
REQ-040 cfg_start pulsed during RUN with different config -> ignored; original stream completes unchanged.
